// File: rtl/scr1_tb_log_pkg.sv
// Shared record layout, default sizing and saturating-counter helper for the instruction match logger.
// Pure declarations: no latency, no handshake.
package scr1_tb_log_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 64;
    localparam int N_CH_DEF  = 4;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [N_CH_DEF-1:0]  hits;
        logic [XLEN_DEF-1:0]  pc;
        logic [XLEN_DEF-1:0]  mstatus;
        logic [CNT_W_DEF-1:0] mcycle;
    } log_rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/scr1_tb_instr_match_log_if.sv
// Fetch observation, channel config and record-stream signals of the instruction match logger.
// The master side drives fetches, config and rec_rdy; the slave side returns records and counters.
interface scr1_tb_instr_match_log_if import scr1_tb_log_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = N_CH_DEF
) ();
    logic              instr_vld;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   mstatus;
    logic [CNT_W-1:0]  mcycle;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic              cfg_en;
    logic [31:0]       cfg_mask;
    logic [31:0]       cfg_val;
    logic              rec_vld;
    logic              rec_rdy;
    logic [N_CH-1:0]   rec_hits;
    logic [XLEN-1:0]   rec_pc;
    logic [XLEN-1:0]   rec_mstatus;
    logic [CNT_W-1:0]  rec_mcycle;
    logic [15:0]       ovf_cnt;
    logic [N_CH*16-1:0] hit_cnt;

    modport master (
        output instr_vld, instr, pc, mstatus, mcycle,
        output cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_val, rec_rdy,
        input  rec_vld, rec_hits, rec_pc, rec_mstatus, rec_mcycle, ovf_cnt, hit_cnt
    );

    modport slave (
        input  instr_vld, instr, pc, mstatus, mcycle,
        input  cfg_we, cfg_idx, cfg_en, cfg_mask, cfg_val, rec_rdy,
        output rec_vld, rec_hits, rec_pc, rec_mstatus, rec_mcycle, ovf_cnt, hit_cnt
    );
endinterface

// File: rtl/scr1_tb_log_fifo.sv
// Generic synchronous FIFO; pushed entry visible at the head one cycle later, no bypass.
// Push is refused when full unless a pop happens on the same edge; head is zero while empty.
module scr1_tb_log_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? T'('0) : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/scr1_tb_instr_match_log.sv
// Matches fetched instructions against N_CH mask/value channels and queues {hits, pc, mstatus, mcycle} records.
// Record visible one cycle after the hitting fetch; rec_rdy pops the head; records arriving on a full queue are counted and dropped.
module scr1_tb_instr_match_log import scr1_tb_log_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_CH  = N_CH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    scr1_tb_instr_match_log_if.slave io
);
    typedef struct packed {
        logic [N_CH-1:0]  hits;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  mstatus;
        logic [CNT_W-1:0] mcycle;
    } rec_t;

    logic [N_CH-1:0] ch_en;
    logic [31:0]     ch_mask [N_CH];
    logic [31:0]     ch_val  [N_CH];
    logic [N_CH-1:0] hits;
    logic            any_hit;
    logic            full;
    logic            empty;
    logic            pop;
    logic            drop;
    rec_t            push_rec;
    rec_t            head_rec;
    logic [15:0]     cnt_q [N_CH];
    logic [15:0]     ovf_q;

    always_comb begin
        hits = '0;
        for (int c = 0; c < N_CH; c++) begin
            hits[c] = io.instr_vld && ch_en[c] && ((io.instr & ch_mask[c]) == ch_val[c]);
        end
    end

    assign any_hit  = |hits;
    assign pop      = !empty && io.rec_rdy;
    assign drop     = any_hit && full && !pop;
    assign push_rec = '{hits: hits, pc: io.pc, mstatus: io.mstatus, mcycle: io.mcycle};

    // Config registers update on the edge, so a same-cycle fetch still sees the old setting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_en <= '0;
            for (int c = 0; c < N_CH; c++) begin
                ch_mask[c] <= '0;
                ch_val[c]  <= '0;
            end
        end else if (io.cfg_we) begin
            for (int c = 0; c < N_CH; c++) begin
                if (io.cfg_idx == 3'(c)) begin
                    ch_en[c]   <= io.cfg_en;
                    ch_mask[c] <= io.cfg_mask;
                    ch_val[c]  <= io.cfg_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
            for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
        end else begin
            ovf_q <= sat_inc16(ovf_q, drop);
            for (int c = 0; c < N_CH; c++) cnt_q[c] <= sat_inc16(cnt_q[c], hits[c]);
        end
    end

    scr1_tb_log_fifo #(
        .T     (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (any_hit),
        .din   (push_rec),
        .pop   (pop),
        .dout  (head_rec),
        .full  (full),
        .empty (empty)
    );

    assign io.rec_vld     = !empty;
    assign io.rec_hits    = head_rec.hits;
    assign io.rec_pc      = head_rec.pc;
    assign io.rec_mstatus = head_rec.mstatus;
    assign io.rec_mcycle  = head_rec.mcycle;
    assign io.ovf_cnt     = ovf_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_hit_cnt
        assign io.hit_cnt[16*c +: 16] = cnt_q[c];
    end

endmodule

// File: tb/tb_scr1_tb_instr_match_log.sv
// Self-checking bench for scr1_tb_instr_match_log: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_scr1_tb_instr_match_log;
    import scr1_tb_log_pkg::*;

    localparam int NCH = 4;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] cyc = 64'h0000_1000_0000_0000;

    always #5 clk = ~clk;

    scr1_tb_instr_match_log_if #(.XLEN(32), .CNT_W(64), .N_CH(NCH)) bus ();

    scr1_tb_instr_match_log #(.XLEN(32), .CNT_W(64), .N_CH(NCH), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct {
        logic [3:0]  hits;
        logic [31:0] pc;
        logic [31:0] ms;
        logic [63:0] mc;
    } mrec_t;

    typedef struct {
        logic [31:0] instr;
        logic        exp_vld;
        logic [3:0]  exp_hits;
    } vec_t;

    mrec_t       mq[$];
    logic [31:0] m_mask [NCH];
    logic [31:0] m_val  [NCH];
    logic        m_en   [NCH];
    int          m_hit  [NCH];
    int          m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mask[c] = '0; m_val[c] = '0; m_en[c] = 1'b0; m_hit[c] = 0;
        end
    endtask

    // One clock edge of the spec: pop head if consumer ready, record hits (drop when no room), then apply config.
    task automatic model_step();
        logic [3:0] h;
        h = '0;
        for (int c = 0; c < NCH; c++)
            if (bus.instr_vld && m_en[c] && ((bus.instr & m_mask[c]) == m_val[c])) h[c] = 1'b1;
        if (mq.size() > 0 && bus.rec_rdy) void'(mq.pop_front());
        if (h != 0) begin
            for (int c = 0; c < NCH; c++) if (h[c] && m_hit[c] < 65535) m_hit[c]++;
            if (mq.size() < DEP) mq.push_back('{h, bus.pc, bus.mstatus, bus.mcycle});
            else if (m_ovf < 65535) m_ovf++;
        end
        if (bus.cfg_we && bus.cfg_idx < NCH) begin
            m_en[bus.cfg_idx]   = bus.cfg_en;
            m_mask[bus.cfg_idx] = bus.cfg_mask;
            m_val[bus.cfg_idx]  = bus.cfg_val;
        end
    endtask

    function automatic logic [63:0] exp_hitcnt();
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[16*c +: 16] = m_hit[c][15:0];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rec_vld"}, bus.rec_vld, mq.size() != 0);
        if (mq.size() != 0) begin
            chk({tag, ".rec_hits"}, bus.rec_hits, mq[0].hits);
            chk({tag, ".rec_pc"}, bus.rec_pc, mq[0].pc);
            chk({tag, ".rec_mstatus"}, bus.rec_mstatus, mq[0].ms);
            chk({tag, ".rec_mcycle"}, bus.rec_mcycle, mq[0].mc);
        end
        chk({tag, ".ovf_cnt"}, bus.ovf_cnt, m_ovf);
        chk({tag, ".hit_cnt"}, bus.hit_cnt, exp_hitcnt());
    endtask

    task automatic tick(input string tag);
        bus.mcycle  = cyc;
        bus.mstatus = $urandom;
        cyc++;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_tick(input string tag);
        bus.instr_vld = 1'b0;
        bus.cfg_we    = 1'b0;
        tick(tag);
    endtask

    task automatic set_cfg(input logic [2:0] idx, input logic en, input logic [31:0] mask, input logic [31:0] val);
        bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_en = en; bus.cfg_mask = mask; bus.cfg_val = val;
        tick("cfg");
        bus.cfg_we = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pcv, input string tag);
        bus.instr_vld = 1'b1; bus.instr = ins; bus.pc = pcv;
        tick(tag);
        bus.instr_vld = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        bus.instr_vld = 1'b0;
        bus.cfg_we    = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_vld"}, bus.rec_vld, 1'b0);
        chk({tag, ".rst_hits"}, bus.rec_hits, 4'h0);
        chk({tag, ".rst_pc"}, bus.rec_pc, 32'h0);
        chk({tag, ".rst_mcycle"}, bus.rec_mcycle, 64'h0);
        chk({tag, ".rst_ovf"}, bus.ovf_cnt, 16'h0);
        chk({tag, ".rst_hitcnt"}, bus.hit_cnt, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cfg_default();
        set_cfg(3'd0, 1'b1, 32'h0000_007F, 32'h0000_0033);
        set_cfg(3'd1, 1'b1, 32'h0000_7000, 32'h0000_6000);
    endtask

    vec_t tbl [5];

    initial begin
        logic [31:0] masks [4];
        logic [7:0]  ops   [4];
        tbl[0] = '{32'h0062_E233, 1'b1, 4'b0011};
        tbl[1] = '{32'h0000_0013, 1'b0, 4'b0000};
        tbl[2] = '{32'h0000_6033, 1'b1, 4'b0011};
        tbl[3] = '{32'h0000_6013, 1'b1, 4'b0010};
        tbl[4] = '{32'h0000_0033, 1'b1, 4'b0001};
        masks = '{32'h0000_007F, 32'h0000_7000, 32'h0000_707F, 32'h0000_0000};
        ops   = '{8'h33, 8'h13, 8'h73, 8'h03};

        bus.instr_vld = 1'b0; bus.instr = '0; bus.pc = '0; bus.mstatus = '0; bus.mcycle = '0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0; bus.cfg_mask = '0; bus.cfg_val = '0;
        bus.rec_rdy = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        do_reset("init");

        // Non-matching fetch leaves everything idle, then the reference hit.
        cfg_default();
        fetch(32'h0000_0013, 32'h0000_0100, "nohit");
        chk("nohit.vld", bus.rec_vld, 1'b0);
        chk("nohit.hitcnt", bus.hit_cnt, 64'h0);
        fetch(32'h0062_E233, 32'h0000_0200, "hit");
        chk("hit.hits", bus.rec_hits, 4'b0011);
        chk("hit.pc", bus.rec_pc, 32'h0000_0200);
        chk("hit.hitcnt", bus.hit_cnt, 64'h0000_0000_0001_0001);
        bus.rec_rdy = 1'b1;
        idle_tick("hit.drain");
        bus.rec_rdy = 1'b0;

        for (int i = 0; i < 5; i++) begin
            fetch(tbl[i].instr, 32'h400 + 32'(i), "tbl");
            chk("tbl.vld", bus.rec_vld, tbl[i].exp_vld);
            if (tbl[i].exp_vld) chk("tbl.hits", bus.rec_hits, tbl[i].exp_hits);
            bus.rec_rdy = 1'b1;
            idle_tick("tbl.drain");
            bus.rec_rdy = 1'b0;
        end

        // Overflow: ten hits into an eight-deep queue, then drain in order.
        do_reset("ovf");
        cfg_default();
        for (int i = 0; i < 10; i++) fetch(32'h0062_E233, 32'h1000 + 32'(4*i), "fill");
        chk("ovf.count", bus.ovf_cnt, 16'd2);
        bus.rec_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf.order", bus.rec_pc, 32'h1000 + 32'(4*i));
            idle_tick("ovf.drain");
        end
        chk("ovf.empty", bus.rec_vld, 1'b0);
        bus.rec_rdy = 1'b0;

        // Full queue with simultaneous push and pop keeps eight entries, new one last.
        for (int i = 0; i < 8; i++) fetch(32'h0000_0033, 32'h2000 + 32'(4*i), "fill2");
        bus.rec_rdy = 1'b1;
        fetch(32'h0000_0033, 32'h0000_3000, "pushpop");
        chk("pushpop.ovf", bus.ovf_cnt, 16'd2);
        for (int i = 1; i < 9; i++) begin
            chk("pushpop.order", bus.rec_pc, (i == 8) ? 32'h3000 : 32'h2000 + 32'(4*i));
            idle_tick("pushpop.drain");
        end
        chk("pushpop.empty", bus.rec_vld, 1'b0);
        bus.rec_rdy = 1'b0;

        // Disabling write in the same cycle as a hit: old config still applies.
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_en = 1'b0;
        bus.cfg_mask = 32'h7F; bus.cfg_val = 32'h33;
        fetch(32'h0000_0033, 32'h0000_5000, "cfgsame");
        bus.cfg_we = 1'b0;
        chk("cfgsame.hits", bus.rec_hits, 4'b0001);
        bus.rec_rdy = 1'b1;
        idle_tick("cfgsame.drain");
        fetch(32'h0000_0033, 32'h0000_5004, "cfgnext");
        chk("cfgnext.vld", bus.rec_vld, 1'b0);
        bus.rec_rdy = 1'b0;

        // Reset with records queued clears queue, counters and config.
        set_cfg(3'd0, 1'b1, 32'h7F, 32'h33);
        for (int i = 0; i < 5; i++) fetch(32'h0062_E233, 32'h6000 + 32'(4*i), "q5");
        do_reset("midrst");
        fetch(32'h0062_E233, 32'h0000_7000, "postrst");
        chk("postrst.vld", bus.rec_vld, 1'b0);
        chk("postrst.hitcnt", bus.hit_cnt, 64'h0);

        // Random traffic, including writes to out-of-range channel indices.
        for (int n = 0; n < 600; n++) begin
            bus.cfg_we = ($urandom_range(0, 5) == 0);
            bus.cfg_idx = 3'($urandom_range(0, 7));
            bus.cfg_en = ($urandom_range(0, 3) != 0);
            bus.cfg_mask = masks[$urandom_range(0, 3)];
            bus.cfg_val = ({$urandom} & 32'hFFFF_8F80 | {17'h0, 3'($urandom_range(0, 7)), 4'h0, ops[$urandom_range(0, 3)]}) & bus.cfg_mask;
            bus.instr_vld = ($urandom_range(0, 3) != 0);
            bus.instr = ({$urandom} & 32'hFFFF_8F00) | {17'h0, 3'($urandom_range(0, 7)), 4'h0, ops[$urandom_range(0, 3)]};
            bus.pc = $urandom;
            bus.rec_rdy = ($urandom_range(0, 9) < 4);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
